// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and constants for the FIFO write arbiter:
//               arbiter state encoding and statistics counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Per-requester accepted-beat counter width and its saturation value
    localparam int               c_cnt_w   = 16;
    localparam logic [c_cnt_w-1:0] c_cnt_sat = 16'hFFFF;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Round-robin selector. Returns the first set request bit found
//               searching upward from i_ptr and wrapping at N_REQ-1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic             o_found,
    output logic [PW-1:0]    o_idx
);

    logic [PW-1:0] w_cand;

    // Scan offsets 0..N_REQ-1 from the pointer; the smallest offset wins
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = PW'((int'(i_ptr) + k) % N_REQ);
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin write arbiter sharing one FIFO write port among
//               N_REQ producers. Each grant is a locked burst of up to
//               MAX_BURST beats; beats are only accepted while the FIFO is
//               not full. Optional per-requester beat statistics are enabled
//               by defining FIFO_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*DW-1:0]      i_data,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_owner,
    output logic                     o_busy,
    input  logic                     i_fifo_full,
    output logic                     o_wr,
    output logic [DW-1:0]            o_din
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*c_cnt_w-1:0] o_beat_cnt_all
`endif
);

    localparam int PW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;

    arb_state_t    r_state;
    logic [PW-1:0] r_owner;
    logic [PW-1:0] r_rr_ptr;
    logic [BW-1:0] r_beats;

    logic          w_found;
    logic [PW-1:0] w_pick_idx;
    logic          w_owner_req;
    logic          w_beat;
    logic          w_last;
    logic [PW-1:0] w_next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    assign w_owner_req = i_req[r_owner];
    // A beat moves only for the locked owner and only with FIFO space
    assign w_beat      = (r_state == ARB_BURST) && w_owner_req && !i_fifo_full;
    assign w_last      = (r_beats == BW'(MAX_BURST - 1));
    assign w_next_ptr  = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + PW'(1);

    // One-hot beat accept for the current owner
    always_comb begin
        o_gnt = '0;
        if (w_beat) begin
            o_gnt[r_owner] = 1'b1;
        end
    end

    assign o_wr    = w_beat;
    assign o_din   = (r_state == ARB_BURST) ? i_data[int'(r_owner)*DW +: DW] : '0;
    assign o_busy  = (r_state == ARB_BURST);
    assign o_owner = r_owner;

    // Arbitration FSM: pick an owner in IDLE, stream its beats in BURST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_beats  <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick_idx;
                        r_beats <= '0;
                        r_state <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (w_beat) begin
                        if (w_last) begin
                            r_state  <= ARB_IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end else begin
                            r_beats <= r_beats + BW'(1);
                        end
                    end else if (!w_owner_req) begin
                        // Owner withdrew: release the port early
                        r_state  <= ARB_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                    // Otherwise the FIFO is full: hold the burst locked
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_stats
            logic [c_cnt_w-1:0] r_cnt;

            // Saturating count of beats accepted from requester g
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (o_gnt[g] && (r_cnt != c_cnt_sat)) begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end

            assign o_beat_cnt_all[g*c_cnt_w +: c_cnt_w] = r_cnt;
        end
    endgenerate
`endif

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter. Producers are data
//               queues (request = queue non-empty), the FIFO is an occupancy
//               counter, and a burst-level model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int FD = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] data = '0;
    logic [N-1:0]    gnt;
    logic [1:0]      owner;
    logic            busy;
    logic            full = 1'b0;
    logic            wr;
    logic [DW-1:0]   din;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DW        (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req),
        .i_data      (data),
        .o_gnt       (gnt),
        .o_owner     (owner),
        .o_busy      (busy),
        .i_fifo_full (full),
        .o_wr        (wr),
        .o_din       (din)
    );

    int checks = 0;
    int errors = 0;

    // Producer queues
    logic [7:0] pbuf [N][256];
    int         phead [N];
    int         ptail [N];

    // Burst-level model: owner (-1 = none), beats still allowed, next start
    int m_owner, m_left, m_next;
    int fcnt;
    int pop_pct;
    bit rand_mode;

    logic [N-1:0] e_gnt;
    logic         e_wr, e_busy;
    logic [7:0]   e_din;

    // Trace capture for literal expectations
    logic       rec_wr  [64];
    logic [7:0] rec_din [64];
    logic [1:0] rec_own [64];
    int         rec_idx;
    logic [7:0] dlog [256];
    int         dlog_n;
    bit         log_en;

    function automatic int pending(int i);
        return ptail[i] - phead[i];
    endfunction

    task automatic push_item(int i, logic [7:0] v);
        pbuf[i][ptail[i] % 256] = v;
        ptail[i]++;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req[i] = (pending(i) > 0);
            data[i*DW +: DW] = (pending(i) > 0) ? pbuf[i][phead[i] % 256] : 8'h00;
        end
        full = (fcnt >= FD);
    endtask

    task automatic model_expect();
        e_gnt  = '0;
        e_busy = (m_owner >= 0);
        e_din  = 8'h00;
        if (m_owner >= 0) begin
            e_din = data[m_owner*DW +: DW];
            if (req[m_owner] && !full) e_gnt[m_owner] = 1'b1;
        end
        e_wr = |e_gnt;
    endtask

    task automatic end_burst();
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
    endtask

    // Apply what happened at the clock edge just passed
    task automatic model_advance();
        int  old_f;
        bit  found;
        old_f = fcnt;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_next + k) % N]) begin
                    found   = 1'b1;
                    m_owner = (m_next + k) % N;
                    m_left  = MB;
                end
            end
        end else if (e_wr) begin
            phead[m_owner]++;
            m_left--;
            if (m_left == 0) end_burst();
        end else if (!req[m_owner]) begin
            end_burst();
        end
        fcnt = fcnt + (e_wr ? 1 : 0);
        if (old_f > 0 && $urandom_range(99) < pop_pct) fcnt--;
    endtask

    task automatic refill();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(99) < 30 && pending(i) < 6)
                push_item(i, 8'($urandom));
        end
    endtask

    // One clock: compare at the falling edge, advance after the rising edge
    task automatic cycle();
        @(negedge clk);
        model_expect();
        check("outputs{busy,wr,gnt,din}", {18'h0, busy, wr, gnt, din},
              {18'h0, e_busy, e_wr, e_gnt, e_din});
        if (e_busy) check("owner", 32'(owner), 32'(m_owner));
        if (rec_idx < 64) begin
            rec_wr[rec_idx]  = wr;
            rec_din[rec_idx] = din;
            rec_own[rec_idx] = owner;
            rec_idx++;
        end
        if (log_en && wr && dlog_n < 256) begin
            dlog[dlog_n] = din;
            dlog_n++;
        end
        @(posedge clk);
        #1;
        model_advance();
        if (rand_mode) refill();
        drive_inputs();
    endtask

    initial begin
        logic [7:0] lit_din [10];
        logic [9:0] lit_wr;
        int         guard;
        int         own_exp [5];

        for (int i = 0; i < N; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
        end
        m_owner = -1; m_left = 0; m_next = 0;
        fcnt = 0; pop_pct = 100; rand_mode = 1'b0;
        rec_idx = 64; dlog_n = 0; log_en = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        drive_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset gnt",   32'(gnt),   32'h0);
        check("reset wr",    32'(wr),    32'h0);
        check("reset busy",  32'(busy),  32'h0);
        check("reset din",   32'(din),   32'h0);
        check("reset owner", 32'(owner), 32'h0);
        rst = 1'b0;

        // Idle with no requests
        rec_idx = 0;
        repeat (10) cycle();
        for (int c = 0; c < 10; c++)
            check("idle wr/busy", {31'h0, rec_wr[c]}, 32'h0);

        // Single requester 2, six beats: burst of 4, bubble, burst of 2
        for (int k = 0; k < 6; k++) push_item(2, 8'(8'hA0 + k));
        drive_inputs();
        rec_idx = 0;
        repeat (10) cycle();
        lit_wr  = 10'b00_1101_1110;
        lit_din = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'hA4, 8'hA5, 8'h00, 8'h00};
        for (int c = 0; c < 10; c++) begin
            check("req2 wr trace",  {31'h0, rec_wr[c]}, {31'h0, lit_wr[c]});
            check("req2 din trace", 32'(rec_din[c]), 32'(lit_din[c]));
            if (lit_wr[c]) check("req2 owner", 32'(rec_own[c]), 32'd2);
        end

        // FIFO fills mid-burst, stays full, then drains; no beat lost
        pop_pct = 0;
        for (int k = 0; k < 24; k++) push_item(1, 8'(8'h10 + k));
        drive_inputs();
        log_en = 1'b1; dlog_n = 0;
        guard = 0;
        while (fcnt < FD && guard < 60) begin
            cycle();
            guard++;
        end
        if (guard >= 60) check("fifo fill timeout", 32'(fcnt), 32'(FD));
        rec_idx = 0;
        repeat (3) cycle();
        for (int c = 0; c < 3; c++)
            check("wr while full", {31'h0, rec_wr[c]}, 32'h0);
        pop_pct = 100;
        guard = 0;
        while (!(m_owner < 0 && pending(1) == 0) && guard < 80) begin
            cycle();
            guard++;
        end
        if (guard >= 80) check("drain timeout", 32'(pending(1)), 32'h0);
        log_en = 1'b0;
        check("stall beats logged", 32'(dlog_n), 32'd24);
        for (int k = 0; k < 24; k++)
            check("stall readback", 32'(dlog[k]), 32'(8'h10 + k));

        // Requester 1 stops after two beats; requester 2 takes over
        push_item(0, 8'h33);
        drive_inputs();
        repeat (4) cycle();
        push_item(1, 8'h51); push_item(1, 8'h52);
        for (int k = 0; k < 4; k++) push_item(2, 8'(8'h60 + k));
        drive_inputs();
        rec_idx = 0;
        repeat (12) cycle();
        guard = 0;
        for (int c = 0; c < 12; c++) begin
            if (rec_wr[c]) begin
                if (guard < 2) check("drop owner first", 32'(rec_own[c]), 32'd1);
                else           check("drop owner next",  32'(rec_own[c]), 32'd2);
                guard++;
            end
        end
        check("drop beat total", 32'(guard), 32'd6);

        // Reset in the middle of a burst, then full four-way rotation
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 20; k++) push_item(i, 8'(i * 32 + k));
        drive_inputs();
        guard = 0;
        while (!(m_owner >= 0 && m_left == MB - 2) && guard < 30) begin
            cycle();
            guard++;
        end
        if (guard >= 30) check("mid-burst timeout", 32'(m_left), 32'(MB - 2));
        #2 rst = 1'b1;
        #1;
        check("rst gnt drop", 32'(gnt), 32'h0);
        check("rst wr drop",  32'(wr),  32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_owner = -1; m_next = 0;
        drive_inputs();
        rec_idx = 0;
        repeat (22) cycle();
        own_exp = '{0, 1, 2, 3, 0};
        for (int b = 0; b < 5; b++) begin
            check("rotation wr",    {31'h0, rec_wr[1 + 5*b]}, 32'h1);
            check("rotation owner", 32'(rec_own[1 + 5*b]), 32'(own_exp[b]));
            if (b < 4) check("rotation bubble", {31'h0, rec_wr[5 + 5*b]}, 32'h0);
        end

        // Randomized traffic with varying FIFO drain rate
        rand_mode = 1'b1;
        for (int r = 0; r < 12; r++) begin
            case (r % 3)
                0:       pop_pct = 95;
                1:       pop_pct = 60;
                default: pop_pct = 30;
            endcase
            repeat (250) cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
